// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, tipo codes,
// FSM encoding and the IF/ID decoded-field bundle.
package fetch_decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // tipo = opcode[6:4], as consumed by the control generator
    localparam logic [2:0] TIPO_LOAD   = 3'b000;
    localparam logic [2:0] TIPO_IMM    = 3'b001;
    localparam logic [2:0] TIPO_STORE  = 3'b010;
    localparam logic [2:0] TIPO_RTYPE  = 3'b011;
    localparam logic [2:0] TIPO_BRANCH = 3'b110;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] tipo;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } if_id_t;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_IMM) || (op == OP_STORE) ||
               (op == OP_RTYPE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Bus between the fetch/decode stage and its environment (imem, hazard
// control, downstream decode). master = the stage, slave = the environment.
interface fetch_decode_stage_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              stall;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic [DATA_W-1:0] pc_out;
    logic [2:0]        tipo;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm;
    logic              valid;
    logic              illegal;
    logic              halted;

    modport master (
        output imem_addr, pc_out, tipo, funct3, funct7,
        output rs1, rs2, rd, imm, valid, illegal, halted,
        input  imem_data, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_addr, pc_out, tipo, funct3, funct7,
        input  rs1, rs2, rd, imm, valid, illegal, halted,
        output imem_data, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_decode_stage_imm_gen.sv
// Combinational immediate generator: instr -> sign-extended imm.
// Ports: instr (fetched word), imm (I/S/B immediate, 0 for R-type/unknown).
module imm_gen
    import fetch_decode_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] imm
);
    logic [6:0] op;

    assign op = instr[6:0];

    always_comb begin
        imm = '0;
        unique case (1'b1)
            (op == OP_LOAD),
            (op == OP_IMM):
                imm = {{(DATA_W-12){instr[31]}}, instr[31:20]};
            (op == OP_STORE):
                imm = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
            (op == OP_BRANCH):
                imm = {{(DATA_W-12){instr[31]}}, instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            default:
                imm = '0;
        endcase
    end
endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch + IF/ID register: PC, imem address, field split and immediate.
// Ports: clk, rst_n (async, active-low), bus (master side of the stage bus).
module fetch_decode_stage
    import fetch_decode_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_decode_stage_if.master  bus
);
    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_out_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] imm_d;
    if_id_t            id_q;
    logic              valid_q;
    logic              illegal_q;
    logic              legal;
    logic              consume;

    imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
        .instr (bus.imem_data),
        .imm   (imm_d)
    );

    assign legal   = is_supported(bus.imem_data[6:0]);
    // the word at pc is consumed only when neither redirected nor stalled
    assign consume = (state_q == RUN) && !bus.branch_taken && !bus.stall;

    always_comb begin
        state_d = state_q;
        if (consume && !legal) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= PC_RESET;
            pc_out_q  <= '0;
            imm_q     <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (state_q == RUN) begin
                if (bus.branch_taken) begin
                    pc_q     <= {bus.branch_target[DATA_W-1:2], 2'b00};
                    pc_out_q <= '0;
                    imm_q    <= '0;
                    id_q     <= '0;
                    valid_q  <= 1'b0;
                end else if (bus.stall) begin
                    pc_q <= pc_q;
                end else if (!legal) begin
                    illegal_q <= 1'b1;
                    pc_out_q  <= '0;
                    imm_q     <= '0;
                    id_q      <= '0;
                    valid_q   <= 1'b0;
                end else begin
                    pc_q        <= pc_q + DATA_W'(PC_STEP);
                    pc_out_q    <= pc_q;
                    imm_q       <= imm_d;
                    id_q.tipo   <= bus.imem_data[6:4];
                    id_q.funct3 <= bus.imem_data[14:12];
                    id_q.funct7 <= bus.imem_data[31:25];
                    id_q.rs1    <= bus.imem_data[19:15];
                    id_q.rs2    <= bus.imem_data[24:20];
                    id_q.rd     <= bus.imem_data[11:7];
                    valid_q     <= 1'b1;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.tipo      = id_q.tipo;
    assign bus.funct3    = id_q.funct3;
    assign bus.funct7    = id_q.funct7;
    assign bus.rs1       = id_q.rs1;
    assign bus.rs2       = id_q.rs2;
    assign bus.rd        = id_q.rd;
    assign bus.imm       = imm_q;
    assign bus.valid     = valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.halted    = (state_q == HALT);
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: random stall/branch traffic
// against a transaction-level model, plus directed corner cases.
module tb_fetch_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fetch_decode_stage_if #(.DATA_W(32)) bus ();

    fetch_decode_stage #(
        .DATA_W   (32),
        .PC_RESET (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] imem_addr;
        logic [31:0] pc_out;
        logic [31:0] imm;
        logic [2:0]  tipo;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
        logic        illegal;
        logic        halted;
    } exp_t;

    exp_t        q[$];
    exp_t        m;
    logic [31:0] m_pc;
    bit          m_halt;
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [5];
        ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h63};
        r = $urandom();
        return {r[31:7], ops[$urandom_range(4)]};
    endfunction

    task automatic mem_rd(input logic [31:0] a, output logic [31:0] d);
        if (!mem.exists(a)) mem[a] = rand_instr();
        d = mem[a];
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        case (i[6:0])
            7'h03, 7'h13: v = int'($signed(i[31:20]));
            7'h23:        v = int'($signed({i[31:25], i[11:7]}));
            7'h63:        v = int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            default:      v = 0;
        endcase
        return v;
    endfunction

    function automatic bit ref_legal(input logic [6:0] op);
        return op inside {7'h03, 7'h13, 7'h23, 7'h33, 7'h63};
    endfunction

    task automatic model_clear();
        m.pc_out = '0; m.imm = '0; m.tipo = '0; m.funct3 = '0;
        m.funct7 = '0; m.rs1 = '0; m.rs2 = '0; m.rd = '0; m.valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_halt = 1'b0;
        model_clear();
        m.illegal = 1'b0;
        m.imem_addr = m_pc;
        m.halted = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit br,
                              input logic [31:0] tgt, input logic [31:0] ins);
        m.illegal = 1'b0;
        if (m_halt) begin
            m.valid = 1'b0;
        end else if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            model_clear();
        end else if (st) begin
            m_pc = m_pc;
        end else if (!ref_legal(ins[6:0])) begin
            model_clear();
            m.illegal = 1'b1;
            m_halt = 1'b1;
        end else begin
            m.pc_out = m_pc;
            m.imm    = ref_imm(ins);
            m.tipo   = ins[6:4];
            m.funct3 = ins[14:12];
            m.funct7 = ins[31:25];
            m.rs1    = ins[19:15];
            m.rs2    = ins[24:20];
            m.rd     = ins[11:7];
            m.valid  = 1'b1;
            m_pc     = m_pc + 32'd4;
        end
        m.imem_addr = m_pc;
        m.halted = m_halt;
    endtask

    task automatic step(input bit st, input bit br, input logic [31:0] tgt);
        logic [31:0] ins;
        mem_rd(m_pc, ins);
        bus.stall = st;
        bus.branch_taken = br;
        bus.branch_target = tgt;
        bus.imem_data = ins;
        model_edge(st, br, tgt, ins);
        q.push_back(m);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_illegal", 32'(bus.illegal), 32'h0);
        check("rst_pc_out", bus.pc_out, 32'h0);
        check("rst_imm", bus.imm, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("imem_addr", bus.imem_addr, e.imem_addr);
                check("pc_out", bus.pc_out, e.pc_out);
                check("imm", bus.imm, e.imm);
                check("tipo", 32'(bus.tipo), 32'(e.tipo));
                check("funct3", 32'(bus.funct3), 32'(e.funct3));
                check("funct7", 32'(bus.funct7), 32'(e.funct7));
                check("rs1", 32'(bus.rs1), 32'(e.rs1));
                check("rs2", 32'(bus.rs2), 32'(e.rs2));
                check("rd", 32'(bus.rd), 32'(e.rd));
                check("valid", 32'(bus.valid), 32'(e.valid));
                check("illegal", 32'(bus.illegal), 32'(e.illegal));
                check("halted", 32'(bus.halted), 32'(e.halted));
            end
        end
    end

    initial begin : stim
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        bus.imem_data = '0;
        mem[32'h0] = 32'h0050_0093;
        mem[32'h4] = 32'hFE20_AE23;
        mem[32'h8] = 32'h4020_8033;
        mem[32'h300] = 32'h0000_007F;
        model_reset();
        do_reset();

        step(1'b0, 1'b0, '0);
        check("addi_imm", bus.imm, 32'd5);
        check("addi_rd", 32'(bus.rd), 32'd1);
        check("addi_tipo", 32'(bus.tipo), 32'd1);
        check("addi_next_addr", bus.imem_addr, 32'd4);

        step(1'b0, 1'b0, '0);
        check("sw_imm", bus.imm, 32'hFFFF_FFFC);
        check("sw_tipo", 32'(bus.tipo), 32'd2);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0);
            check("stall_addr", bus.imem_addr, 32'd8);
            check("stall_valid", 32'(bus.valid), 32'd1);
        end

        step(1'b0, 1'b0, '0);
        check("sub_funct7", 32'(bus.funct7), 32'h20);
        check("sub_tipo", 32'(bus.tipo), 32'd3);
        check("after_stall_addr", bus.imem_addr, 32'd12);

        step(1'b1, 1'b1, 32'h0000_0043);
        check("branch_addr", bus.imem_addr, 32'h40);
        check("branch_flush", 32'(bus.valid), 32'd0);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(3) == 0, $urandom_range(9) == 0,
                 32'($urandom_range(32'h200)));
        end

        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        check("wrap_tgt", bus.imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, '0);
        check("wrap_addr", bus.imem_addr, 32'h0);
        check("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);

        step(1'b0, 1'b1, 32'h300);
        step(1'b1, 1'b0, '0);
        check("ill_stalled", 32'(bus.illegal), 32'd0);
        step(1'b0, 1'b0, '0);
        check("ill_pulse", 32'(bus.illegal), 32'd1);
        check("ill_halted", 32'(bus.halted), 32'd1);
        step(1'b0, 1'b1, 32'h40);
        check("ill_one_cycle", 32'(bus.illegal), 32'd0);
        check("halt_addr", bus.imem_addr, 32'h300);
        step(1'b0, 1'b0, '0);

        do_reset();
        step(1'b0, 1'b0, '0);
        check("post_reset_valid", 32'(bus.valid), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
